// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Upstream stage for a combinational 4-bit ripple adder. Operand pairs are
//   buffered in a small FIFO, presented one pair at a time on add_v1/add_v2,
//   and the returned 5-bit sum is captured into an output register that is
//   handed to the consumer with a valid/ready handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake; in_a/in_b are the operands
//   add_v1/add_v2         registered operands driven to the adder
//   add_sum               adder result (bit 4 = carry)
//   out_valid/out_ready   result handshake; out_sum/out_carry are the result
//   fifo_count            number of pairs waiting in the FIFO
//   done_cnt              results handed off, wraps 255 -> 0
module adder_operand_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic [3:0]               add_v1,
  output logic [3:0]               add_v2,
  input  logic [4:0]               add_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_sum,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               done_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      v1_q, v1_d;
  logic [3:0]      v2_q, v2_d;
  logic [4:0]      sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            valid_q, valid_d;
  logic [7:0]      done_q, done_d;

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      head;
  logic            push;
  logic            pop;
  logic            fifo_empty;

  // Decoded from registers only so the upstream never sees a combinational path.
  assign in_ready   = (count_q != CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    done_d   = done_q;
    pop      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          v1_d    = head[7:4];
          v2_d    = head[3:0];
          pop     = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        sum_d   = add_sum;
        carry_d = add_sum[4];
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (valid_q && out_ready) begin
          done_d  = done_q + 8'd1;
          valid_d = 1'b0;
          // Hand-off and the next load share one edge to sustain 1 result / 2 cycles.
          if (!fifo_empty) begin
            v1_d    = head[7:4];
            v2_d    = head[3:0];
            pop     = 1'b1;
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  assign add_v1     = v1_q;
  assign add_v2     = v2_q;
  assign out_sum    = sum_q;
  assign out_carry  = carry_q;
  assign out_valid  = valid_q;
  assign fifo_count = count_q;
  assign done_cnt   = done_q;

endmodule
